// File: rtl/ldpc_sched_pkg.sv
// Shared types and default sizing for the LDPC iteration scheduler.
package ldpc_sched_pkg;

    localparam int DEF_N_ROWS   = 21;
    localparam int DEF_MAX_ITER = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROW,
        S_JUDGE,
        S_JWAIT,
        S_UPD,
        S_FIN
    } state_t;

    typedef enum logic [2:0] {
        P_RD,
        P_EXP,
        P_ADD,
        P_MIN,
        P_WR,
        P_CMP
    } phase_t;

endpackage

// File: rtl/ldpc_row_seq.sv
// Row/phase sequencer: owns the row counter, walks the six per-row phases and
// drives the registered RAM strobes and datapath stage enables.
module ldpc_row_seq
    import ldpc_sched_pkg::*;
#(
    parameter int N_ROWS = DEF_N_ROWS,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              ld_beat,
    input  logic              go,
    output logic              ld_last,
    output logic              fin,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic              exp_en,
    output logic              add_en,
    output logic              min_en,
    output logic              cmp_en
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_ROWS - 1);

    logic              active, active_n;
    phase_t            phase, phase_n;
    logic [ADDR_W-1:0] row, row_n;
    logic              re_n, we_n, exp_n, add_n, min_n, cmp_n;
    logic [ADDR_W-1:0] raddr_n, waddr_n;

    assign ld_last = (row == LAST_ROW);
    assign fin     = active && (phase == P_CMP) && (row == LAST_ROW);

    always_comb begin
        active_n = active;
        phase_n  = phase;
        row_n    = row;
        re_n     = 1'b0;
        we_n     = 1'b0;
        exp_n    = 1'b0;
        add_n    = 1'b0;
        min_n    = 1'b0;
        cmp_n    = 1'b0;
        raddr_n  = ram_raddr;
        waddr_n  = ram_waddr;

        if (clr) begin
            active_n = 1'b0;
            phase_n  = P_RD;
            row_n    = '0;
        end else if (ld_beat) begin
            we_n    = 1'b1;
            waddr_n = row;
            row_n   = (row == LAST_ROW) ? '0 : row + ADDR_W'(1);
        end else if (go) begin
            active_n = 1'b1;
            phase_n  = P_RD;
            row_n    = '0;
        end else if (active) begin
            if (phase == P_CMP) begin
                phase_n = P_RD;
                if (row == LAST_ROW) begin
                    active_n = 1'b0;
                    row_n    = '0;
                end else begin
                    row_n = row + ADDR_W'(1);
                end
            end else begin
                phase_n = phase_t'(phase + 3'd1);
            end
        end

        // Strobes are registered for the phase being entered, so each one
        // lines up with the cycle in which that phase is current.
        if (active_n) begin
            case (phase_n)
                P_RD: begin
                    re_n    = 1'b1;
                    raddr_n = row_n;
                end
                P_EXP: exp_n = 1'b1;
                P_ADD: add_n = 1'b1;
                P_MIN: min_n = 1'b1;
                P_WR: begin
                    we_n    = 1'b1;
                    waddr_n = row_n;
                end
                P_CMP: cmp_n = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            phase     <= P_RD;
            row       <= '0;
            ram_re    <= 1'b0;
            ram_raddr <= '0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            exp_en    <= 1'b0;
            add_en    <= 1'b0;
            min_en    <= 1'b0;
            cmp_en    <= 1'b0;
        end else begin
            active    <= active_n;
            phase     <= phase_n;
            row       <= row_n;
            ram_re    <= re_n;
            ram_raddr <= raddr_n;
            ram_we    <= we_n;
            ram_waddr <= waddr_n;
            exp_en    <= exp_n;
            add_en    <= add_n;
            min_en    <= min_n;
            cmp_en    <= cmp_n;
        end
    end

endmodule

// File: rtl/ldpc_iter_sched.sv
// Frame-level scheduler: load, initial check, then row sweeps / check / update
// until the syndrome clears or the iteration limit is hit. All outputs registered.
module ldpc_iter_sched
    import ldpc_sched_pkg::*;
#(
    parameter int N_ROWS   = DEF_N_ROWS,
    parameter int ADDR_W   = 5,
    parameter int MAX_ITER = DEF_MAX_ITER,
    parameter int ITER_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              llr_valid,
    output logic              llr_ready,
    input  logic              chk_ok,
    output logic              sel_load,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic              exp_en,
    output logic              add_en,
    output logic              min_en,
    output logic              cmp_en,
    output logic              chk_en,
    output logic              upd_en,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic [ITER_W-1:0] iter_cnt
);

    state_t            state, state_n;
    logic              llr_ready_n, sel_load_n, chk_en_n, upd_en_n;
    logic              busy_n, done_n, success_n;
    logic [ITER_W-1:0] iter_n;
    logic              seq_clr, seq_ld, seq_go, ld_last, row_fin;

    ldpc_row_seq #(
        .N_ROWS (N_ROWS),
        .ADDR_W (ADDR_W)
    ) u_row_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (seq_clr),
        .ld_beat   (seq_ld),
        .go        (seq_go),
        .ld_last   (ld_last),
        .fin       (row_fin),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .exp_en    (exp_en),
        .add_en    (add_en),
        .min_en    (min_en),
        .cmp_en    (cmp_en)
    );

    always_comb begin
        state_n     = state;
        llr_ready_n = 1'b0;
        sel_load_n  = sel_load;
        chk_en_n    = 1'b0;
        upd_en_n    = 1'b0;
        done_n      = 1'b0;
        success_n   = success;
        iter_n      = iter_cnt;
        seq_clr     = 1'b0;
        seq_ld      = 1'b0;
        seq_go      = 1'b0;

        if (abort) begin
            state_n    = S_IDLE;
            sel_load_n = 1'b1;
            success_n  = 1'b0;
            seq_clr    = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n     = S_LOAD;
                        llr_ready_n = 1'b1;
                        sel_load_n  = 1'b1;
                        success_n   = 1'b0;
                        iter_n      = '0;
                        seq_clr     = 1'b1;
                    end
                end
                S_LOAD: begin
                    llr_ready_n = 1'b1;
                    if (llr_valid && llr_ready) begin
                        seq_ld = 1'b1;
                        if (ld_last) begin
                            llr_ready_n = 1'b0;
                            state_n     = S_JUDGE;
                        end
                    end
                end
                S_ROW: begin
                    if (row_fin) state_n = S_JUDGE;
                end
                S_JUDGE: begin
                    // The last load word is written while in JUDGE, so the
                    // write mux leaves the load path only after that cycle.
                    sel_load_n = 1'b0;
                    chk_en_n   = 1'b1;
                    state_n    = S_JWAIT;
                end
                S_JWAIT: begin
                    // chk_ok is only meaningful the cycle after chk_en.
                    if (!chk_en) begin
                        if (chk_ok) begin
                            success_n  = 1'b1;
                            done_n     = 1'b1;
                            sel_load_n = 1'b1;
                            state_n    = S_FIN;
                        end else if (iter_cnt == ITER_W'(MAX_ITER)) begin
                            success_n  = 1'b0;
                            done_n     = 1'b1;
                            sel_load_n = 1'b1;
                            state_n    = S_FIN;
                        end else begin
                            upd_en_n = 1'b1;
                            iter_n   = iter_cnt + ITER_W'(1);
                            state_n  = S_UPD;
                        end
                    end
                end
                S_UPD: begin
                    seq_go  = 1'b1;
                    state_n = S_ROW;
                end
                S_FIN: state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            llr_ready <= 1'b0;
            sel_load  <= 1'b1;
            chk_en    <= 1'b0;
            upd_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            success   <= 1'b0;
            iter_cnt  <= '0;
        end else begin
            state     <= state_n;
            llr_ready <= llr_ready_n;
            sel_load  <= sel_load_n;
            chk_en    <= chk_en_n;
            upd_en    <= upd_en_n;
            busy      <= busy_n;
            done      <= done_n;
            success   <= success_n;
            iter_cnt  <= iter_n;
        end
    end

endmodule
